pcm_dac_serializer: RTL and testbench
=====================================

// Module: pcm_dac_serializer
// PURPOSE
//  Parametrised successor of the single-channel PCM1702 serial interface. Adds:
//   - NCH channels in lock-step, with a shared bclk/le and one sdata line per channel
//   - a synchronous bclk divider (no ripple clocks)
//   - a valid/ready input with a 1-deep holding buffer, so back-to-back frames run gap-free
//   - an underrun flag
//  Sits between the interpolation/sample pipeline and the external PCM17xx-style DACs.
// PARAMETERS
//  DATA_W    20  bits per sample, shifted MSB first (>=2)
//  NCH        2  number of channels / sdata lines (>=1)
//  HALF_DIV   8  bclk half-period in clk cycles (>=2); bclk period = 2*HALF_DIV clk
//  LE_BCLKS   1  le-low duration, in bclk periods (>=1)
//  CONT_MODE  1  1: flag underrun when a frame ends with the buffer empty; 0: never flag
// PORTS
//  clk         in   1             system clock, all logic on posedge
//  rst         in   1             asynchronous, active-low reset
//  s_valid     in   1             input sample set valid
//  s_ready     out  1             buffer empty; transfer occurs when s_valid & s_ready
//  s_data      in   NCH*DATA_W    ch k = s_data[k*DATA_W +: DATA_W], signed two's complement
//  bclk        out  1             DAC bit clock; the DAC samples sdata on its rising edge
//  sdata       out  NCH           per-channel serial data, bit k drives channel k
//  le          out  1             latch enable, active low after LSB
//  frame_done  out  1             1-clk pulse when le returns high
//  busy        out  1             state != IDLE
//  underrun    out  1             1-clk pulse, see BEHAVIOUR
// BEHAVIOUR
//  Reset (rst=0, async):
//   - bclk=0, le=1, sdata=0, frame_done=0, underrun=0, busy=0
//   - buffer empty (s_ready=1), state IDLE, divider count 0
//   - s_valid is ignored while rst=0
//   - rst asserted mid-frame aborts the frame immediately; no partial le pulse
//  bclk generation:
//   - free-running from reset release; bclk toggles when cnt==HALF_DIV-1, then cnt<=0
//   - fall_tick = the cycle in which bclk is 1 and cnt==HALF_DIV-1
//   - All sdata/le/state updates occur only on fall_tick, at the same clk edge that bclk falls
//  Buffer:
//   - acceptance writes the buffer, s_ready<=0
//   - a load into the shifter empties it
//   - load and accept in the same cycle: the buffer ends full, holding the new data
//  FSM:
//   - IDLE: sdata=0, le=1. On fall_tick with buffer full: load the shifter, bitcnt<=0 -> SHIFT.
//   - SHIFT: sdata[k] = MSB of shifter k. On each fall_tick:
//     - if bitcnt==DATA_W-1: sdata<=0, le<=0, lecnt<=0 -> LATCH
//     - else: shift left, bitcnt++
//   - LATCH: le=0. On each fall_tick:
//     - if lecnt==LE_BCLKS-1: le<=1, frame_done pulses; then
//       - buffer full: load and go to SHIFT (back-to-back, no idle bclk period)
//       - else: IDLE, and underrun pulses if CONT_MODE
//     - else: lecnt++
//  Latency:
//   - first MSB appears at the first fall_tick after acceptance
//   - frame length = (DATA_W+LE_BCLKS) bclk periods
//  Each channel sees identical bit timing.
//  Widths:
//   - bitcnt and lecnt are $clog2 sized
//   - cnt is $clog2(HALF_DIV) sized
//   - no arithmetic on the data path
// STRUCTURE
//  Package pcm_dac_pkg:
//   - state encoding: IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2
//   - localparam defaults for DATA_W and HALF_DIV
//  Sub-module pcm_bclk_gen (HALF_DIV): outputs bclk and fall_tick, async active-low reset.
//  The top level holds the FSM, the holding buffer and NCH shift registers (generate loop).
// TESTING
//  1. Reset with default parameters, single sample ch0=20'hA5A5A, ch1=20'h5A5A5:
//     - sdata[0] reads A5A5A and sdata[1] reads 5A5A5, captured MSB first on 20 bclk rises
//     - le low for 1 bclk, then frame_done pulses once
//  2. Continuous stream of 4 sample sets, s_valid held high:
//     - four frames back-to-back, each 21 bclk periods
//     - no underrun until after the 4th frame, then underrun pulses once
//  3. s_valid asserted in the same cycle as a load fall_tick:
//     - the buffer holds the new data, s_ready=0
//     - the next frame carries the new data, with no sample lost or duplicated
//  4. rst driven low during bit 10 of a frame:
//     - bclk, sdata and le go to 0, 0 and 1 immediately
//     - after release, the next sample frames cleanly from its MSB
//  5. Parameter sweep DATA_W=16, NCH=1, HALF_DIV=2, LE_BCLKS=3:
//     - bclk period is 4 clk
//     - le stays low for exactly 12 clk
//     - 16 bits are captured MSB first
//  6. CONT_MODE=0 with a single frame: underrun stays 0 throughout.

Source files
------------

// File: rtl/pcm_dac_pkg.sv
// Shared types and defaults for the multi-channel PCM17xx-style DAC serializer.
package pcm_dac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam int DEF_DATA_W   = 20;
   localparam int DEF_HALF_DIV = 8;

   // Counter width that stays at least one bit when the terminal count is zero.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pcm_bclk_gen.sv
// Free-running bit clock generated as a registered toggle, plus a one-cycle
// strobe marking the system clock edge on which bclk falls.
module pcm_bclk_gen
   import pcm_dac_pkg::*;
#(
   parameter int HALF_DIV = DEF_HALF_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic bclk,
   output logic fall_tick
);

   localparam int                CNT_W    = cnt_w(HALF_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HALF_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_bclk;
   logic             w_wrap;

   assign w_wrap = (r_cnt == CNT_LAST);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_bclk <= 1'b0;
      end else if (w_wrap) begin
         r_cnt  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign bclk      = r_bclk;
   assign fall_tick = r_bclk & w_wrap;

endmodule

// File: rtl/pcm_dac_serializer.sv
// NCH-channel PCM DAC serializer: shared bclk/le, one sdata line per channel,
// valid/ready input with a one-deep holding buffer for gap-free frames.
module pcm_dac_serializer
   import pcm_dac_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NCH       = 2,
   parameter int HALF_DIV  = DEF_HALF_DIV,
   parameter int LE_BCLKS  = 1,
   parameter int CONT_MODE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [NCH*DATA_W-1:0] s_data,
   output logic                  bclk,
   output logic [NCH-1:0]        sdata,
   output logic                  le,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  underrun
);

   localparam int               BIT_W    = cnt_w(DATA_W);
   localparam int               LE_W     = cnt_w(LE_BCLKS);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_BCLKS - 1);

   state_t                  r_state;
   logic [BIT_W-1:0]        r_bitcnt;
   logic [LE_W-1:0]         r_lecnt;
   logic                    r_le;
   logic                    r_frame_done;
   logic                    r_underrun;
   logic [NCH*DATA_W-1:0]   r_buf;
   logic                    r_buf_full;

   logic w_bclk;
   logic w_fall;
   logic w_accept;
   logic w_last_bit;
   logic w_last_le;
   logic w_load;
   logic w_shift;
   logic w_clear;

   pcm_bclk_gen #(
      .HALF_DIV (HALF_DIV)
   ) u_bclk_gen (
      .clk       (clk),
      .rst       (rst),
      .bclk      (w_bclk),
      .fall_tick (w_fall)
   );

   assign w_accept   = s_valid & ~r_buf_full;
   assign w_last_bit = (r_bitcnt == BIT_LAST);
   assign w_last_le  = (r_lecnt == LE_LAST);

   // A load happens from IDLE or straight out of the final le period (back-to-back).
   assign w_load  = w_fall & r_buf_full &
                    ((r_state == ST_IDLE) | ((r_state == ST_LATCH) & w_last_le));
   assign w_shift = w_fall & (r_state == ST_SHIFT) & ~w_last_bit;
   assign w_clear = w_fall & (r_state == ST_SHIFT) & w_last_bit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf_full <= 1'b0;
      end else if (w_accept) begin
         r_buf_full <= 1'b1;
      end else if (w_load) begin
         r_buf_full <= 1'b0;
      end
   end

   // NOTE: pure data registers carry no reset; the full flag and FSM state gate their use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_bitcnt     <= '0;
         r_lecnt      <= '0;
         r_le         <= 1'b1;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
         if (w_fall) begin
            unique case (r_state)
               ST_IDLE: begin
                  if (r_buf_full) begin
                     r_bitcnt <= '0;
                     r_state  <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (w_last_bit) begin
                     r_le    <= 1'b0;
                     r_lecnt <= '0;
                     r_state <= ST_LATCH;
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
               ST_LATCH: begin
                  if (w_last_le) begin
                     r_le         <= 1'b1;
                     r_frame_done <= 1'b1;
                     if (r_buf_full) begin
                        r_bitcnt <= '0;
                        r_state  <= ST_SHIFT;
                     end else begin
                        r_underrun <= (CONT_MODE != 0);
                        r_state    <= ST_IDLE;
                     end
                  end else begin
                     r_lecnt <= r_lecnt + 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Each channel keeps its current bit in r_sd and the remaining bits in r_rest.
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [DATA_W-2:0] r_rest;
      logic              r_sd;

      always_ff @(posedge clk) begin
         if (w_load) begin
            r_rest <= r_buf[k*DATA_W +: DATA_W-1];
         end else if (w_shift) begin
            r_rest <= r_rest << 1;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_sd <= 1'b0;
         end else if (w_load) begin
            r_sd <= r_buf[k*DATA_W + DATA_W-1];
         end else if (w_shift) begin
            r_sd <= r_rest[DATA_W-2];
         end else if (w_clear) begin
            r_sd <= 1'b0;
         end
      end

      assign sdata[k] = r_sd;
   end

   assign s_ready    = ~r_buf_full;
   assign bclk       = w_bclk;
   assign le         = r_le;
   assign frame_done = r_frame_done;
   assign busy       = (r_state != ST_IDLE);
   assign underrun   = r_underrun;

endmodule

// File: tb/tb_pcm_dac_serializer.sv
// Directed bench: default 2-channel build, a DATA_W=16/HALF_DIV=2/LE_BCLKS=3 build
// and a CONT_MODE=0 build, all sampled on the falling edge of clk.
module tb_pcm_dac_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- DUT A: defaults (DATA_W=20, NCH=2, HALF_DIV=8, LE_BCLKS=1) ----
   logic        a_rst, a_valid, a_ready, a_bclk, a_le, a_fd, a_busy, a_ur;
   logic [39:0] a_data;
   logic [1:0]  a_sdata;

   pcm_dac_serializer #(.DATA_W(20), .NCH(2), .HALF_DIV(8), .LE_BCLKS(1), .CONT_MODE(1)) u_dut_a (
      .clk(clk), .rst(a_rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
      .bclk(a_bclk), .sdata(a_sdata), .le(a_le), .frame_done(a_fd), .busy(a_busy),
      .underrun(a_ur));

   // ---------------- DUT B: DATA_W=16, NCH=1, HALF_DIV=2, LE_BCLKS=3 ----------------
   logic        b_rst, b_valid, b_ready, b_bclk, b_le, b_fd, b_busy, b_ur;
   logic [15:0] b_data;
   logic [0:0]  b_sdata;

   pcm_dac_serializer #(.DATA_W(16), .NCH(1), .HALF_DIV(2), .LE_BCLKS(3), .CONT_MODE(1)) u_dut_b (
      .clk(clk), .rst(b_rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
      .bclk(b_bclk), .sdata(b_sdata), .le(b_le), .frame_done(b_fd), .busy(b_busy),
      .underrun(b_ur));

   // ---------------- DUT C: defaults with CONT_MODE=0 ----------------------------
   logic        c_rst, c_valid, c_ready, c_bclk, c_le, c_fd, c_busy, c_ur;
   logic [39:0] c_data;
   logic [1:0]  c_sdata;

   pcm_dac_serializer #(.DATA_W(20), .NCH(2), .HALF_DIV(8), .LE_BCLKS(1), .CONT_MODE(0)) u_dut_c (
      .clk(clk), .rst(c_rst), .s_valid(c_valid), .s_ready(c_ready), .s_data(c_data),
      .bclk(c_bclk), .sdata(c_sdata), .le(c_le), .frame_done(c_fd), .busy(c_busy),
      .underrun(c_ur));

   // ---------------- Capture monitors (behave like the DAC: sample on bclk rise) ----
   logic        a_bclk_q = 1'b0;
   logic [19:0] a_cap0, a_cap1;
   int          a_nb = 0, a_fd_n = 0, a_ur_n = 0, a_le_run = 0, a_le_last = 0, a_ur_cyc = 0;
   int          a_fd_cyc[$], a_nbq[$];
   logic [19:0] a_w0[$], a_w1[$];

   always @(negedge clk) begin
      if (!a_rst) begin
         a_nb     = 0;
         a_le_run = 0;
      end else begin
         if (a_bclk && !a_bclk_q && a_busy && a_le) begin
            a_cap0 = {a_cap0[18:0], a_sdata[0]};
            a_cap1 = {a_cap1[18:0], a_sdata[1]};
            a_nb++;
         end
         if (!a_le) a_le_run++;
         else if (a_le_run != 0) begin
            a_le_last = a_le_run;
            a_le_run  = 0;
         end
         if (a_fd) begin
            a_w0.push_back(a_cap0);
            a_w1.push_back(a_cap1);
            a_nbq.push_back(a_nb);
            a_fd_cyc.push_back(cyc);
            a_nb = 0;
            a_fd_n++;
         end
         if (a_ur) begin
            a_ur_n++;
            a_ur_cyc = cyc;
         end
      end
      a_bclk_q = a_bclk;
   end

   logic        b_bclk_q = 1'b0;
   logic [15:0] b_cap;
   int          b_nb = 0, b_fd_n = 0, b_le_run = 0, b_le_last = 0;
   int          b_fd_cyc[$], b_nbq[$];
   logic [15:0] b_w[$];

   always @(negedge clk) begin
      if (b_rst) begin
         if (b_bclk && !b_bclk_q && b_busy && b_le) begin
            b_cap = {b_cap[14:0], b_sdata[0]};
            b_nb++;
         end
         if (!b_le) b_le_run++;
         else if (b_le_run != 0) begin
            b_le_last = b_le_run;
            b_le_run  = 0;
         end
         if (b_fd) begin
            b_w.push_back(b_cap);
            b_nbq.push_back(b_nb);
            b_fd_cyc.push_back(cyc);
            b_nb = 0;
            b_fd_n++;
         end
      end
      b_bclk_q = b_bclk;
   end

   logic        c_bclk_q = 1'b0;
   logic [19:0] c_cap0, c_cap1;
   int          c_nb = 0, c_fd_n = 0, c_ur_n = 0;
   logic [19:0] c_w0[$], c_w1[$];

   always @(negedge clk) begin
      if (c_rst) begin
         if (c_bclk && !c_bclk_q && c_busy && c_le) begin
            c_cap0 = {c_cap0[18:0], c_sdata[0]};
            c_cap1 = {c_cap1[18:0], c_sdata[1]};
            c_nb++;
         end
         if (c_fd) begin
            c_w0.push_back(c_cap0);
            c_w1.push_back(c_cap1);
            c_fd_n++;
         end
         if (c_ur) c_ur_n++;
      end
      c_bclk_q = c_bclk;
   end

   // ---------------- Driver helpers (called at a negedge, return at a negedge) -------
   task automatic send_a(input logic [19:0] d0, input logic [19:0] d1);
      int k = 0;
      a_valid = 1'b1;
      a_data  = {d1, d0};
      while (!a_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("a_send_ready", a_ready, 1'b1);
      @(negedge clk);
   endtask

   task automatic send_b(input logic [15:0] d);
      int k = 0;
      b_valid = 1'b1;
      b_data  = d;
      while (!b_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("b_send_ready", b_ready, 1'b1);
      @(negedge clk);
   endtask

   task automatic wait_frames(input int which, input int target, input int budget);
      int k = 0;
      int cnt;
      cnt = (which == 0) ? a_fd_n : (which == 1) ? b_fd_n : c_fd_n;
      while (cnt < target && k < budget) begin
         @(negedge clk);
         k++;
         cnt = (which == 0) ? a_fd_n : (which == 1) ? b_fd_n : c_fd_n;
      end
      check($sformatf("frame_wait_%0d", which), cnt, target);
   endtask

   task automatic wait_a_bclk(input logic lvl);
      logic prev;
      int   k = 0;
      prev = a_bclk;
      @(negedge clk);
      while (!(a_bclk == lvl && prev != lvl) && k < 100) begin
         prev = a_bclk;
         @(negedge clk);
         k++;
      end
      check("a_bclk_edge", a_bclk, lvl);
   endtask

   logic [19:0] t2_d0[4] = '{20'h12345, 20'hFFFFF, 20'h00001, 20'h80000};
   logic [19:0] t2_d1[4] = '{20'hABCDE, 20'h00000, 20'h7FFFF, 20'hC0FFE};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, ur_base, k;
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      a_valid = 1'b1; a_data = 40'hFFFFF_FFFFF;
      b_valid = 1'b0; b_data = '0;
      c_valid = 1'b0; c_data = '0;
      repeat (4) @(negedge clk);

      // Reset state, with s_valid held high to show it is ignored
      check("rst_bclk",   a_bclk,  1'b0);
      check("rst_le",     a_le,    1'b1);
      check("rst_sdata",  a_sdata, 2'b00);
      check("rst_fd",     a_fd,    1'b0);
      check("rst_ur",     a_ur,    1'b0);
      check("rst_busy",   a_busy,  1'b0);
      check("rst_ready",  a_ready, 1'b1);
      a_valid = 1'b0;
      @(negedge clk);
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_ready", a_ready, 1'b1);
      check("post_rst_busy",  a_busy,  1'b0);

      // 1. Single frame on the default build
      send_a(20'hA5A5A, 20'h5A5A5);
      a_valid = 1'b0;
      wait_frames(0, 1, 2000);
      repeat (40) @(negedge clk);
      check("t1_ch0",    a_w0[0],  20'hA5A5A);
      check("t1_ch1",    a_w1[0],  20'h5A5A5);
      check("t1_nbits",  a_nbq[0], 20);
      check("t1_le_low", a_le_last, 16);
      check("t1_fd_cnt", a_fd_n,   1);
      check("t1_ur_cnt", a_ur_n,   1);
      check("t1_ur_at_end", a_ur_cyc, a_fd_cyc[0]);

      // 2. Four back-to-back frames with s_valid held high
      base = a_fd_n; ur_base = a_ur_n;
      for (int i = 0; i < 4; i++) send_a(t2_d0[i], t2_d1[i]);
      a_valid = 1'b0;
      wait_frames(0, base + 4, 6000);
      repeat (40) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_ch0_%0d", i), a_w0[base+i],  t2_d0[i]);
         check($sformatf("t2_ch1_%0d", i), a_w1[base+i],  t2_d1[i]);
         check($sformatf("t2_nb_%0d", i),  a_nbq[base+i], 20);
         if (i > 0)
            check($sformatf("t2_gap_%0d", i), a_fd_cyc[base+i] - a_fd_cyc[base+i-1], 336);
      end
      check("t2_ur_cnt",    a_ur_n,   ur_base + 1);
      check("t2_ur_at_end", a_ur_cyc, a_fd_cyc[base+3]);

      // 3. s_valid raised in the very cycle of the load fall_tick
      base = a_fd_n; ur_base = a_ur_n;
      wait_a_bclk(1'b0);
      send_a(20'h0F0F0, 20'h33333);
      a_valid = 1'b0;
      wait_a_bclk(1'b1);
      repeat (7) @(negedge clk);
      check("t3_ready_pre", a_ready, 1'b0);
      check("t3_busy_pre",  a_busy,  1'b0);
      send_a(20'hF0F0F, 20'hCCCCC);
      a_valid = 1'b0;
      check("t3_ready_hold", a_ready, 1'b0);
      check("t3_busy",       a_busy,  1'b1);
      wait_frames(0, base + 2, 2000);
      repeat (40) @(negedge clk);
      check("t3_f0_ch0", a_w0[base],   20'h0F0F0);
      check("t3_f0_ch1", a_w1[base],   20'h33333);
      check("t3_f1_ch0", a_w0[base+1], 20'hF0F0F);
      check("t3_f1_ch1", a_w1[base+1], 20'hCCCCC);
      check("t3_fd_cnt", a_fd_n, base + 2);
      check("t3_gap",    a_fd_cyc[base+1] - a_fd_cyc[base], 336);
      check("t3_ur_cnt", a_ur_n, ur_base + 1);

      // 4. Reset asserted mid-frame
      base = a_fd_n;
      send_a(20'hFFFFF, 20'hFFFFF);
      a_valid = 1'b0;
      k = 0;
      while (!(a_nb == 10 && a_bclk) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("t4_pre_bclk",  a_bclk,  1'b1);
      check("t4_pre_sdata", a_sdata, 2'b11);
      a_rst = 1'b0;
      #1;
      check("t4_abort_bclk",  a_bclk,  1'b0);
      check("t4_abort_sdata", a_sdata, 2'b00);
      check("t4_abort_le",    a_le,    1'b1);
      check("t4_abort_busy",  a_busy,  1'b0);
      repeat (3) @(negedge clk);
      check("t4_rst_le", a_le, 1'b1);
      a_rst = 1'b1;
      send_a(20'h80001, 20'h7FFFE);
      a_valid = 1'b0;
      wait_frames(0, base + 1, 2000);
      check("t4_ch0",    a_w0[base],  20'h80001);
      check("t4_ch1",    a_w1[base],  20'h7FFFE);
      check("t4_nbits",  a_nbq[base], 20);

      // 5. DATA_W=16, NCH=1, HALF_DIV=2, LE_BCLKS=3
      k = 0;
      while (!(b_bclk && !b_bclk_q) && k < 20) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      @(negedge clk);
      k++;
      while (!(b_bclk && !b_bclk_q) && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("t5_bclk_period", k, 4);
      send_b(16'hC3A5);
      send_b(16'h0001);
      b_valid = 1'b0;
      wait_frames(1, 2, 1000);
      check("t5_w0",     b_w[0],   16'hC3A5);
      check("t5_w1",     b_w[1],   16'h0001);
      check("t5_nb0",    b_nbq[0], 16);
      check("t5_nb1",    b_nbq[1], 16);
      check("t5_le_low", b_le_last, 12);
      check("t5_gap",    b_fd_cyc[1] - b_fd_cyc[0], 76);

      // 6. CONT_MODE=0: a lone frame never flags underrun
      c_valid = 1'b1;
      c_data  = {20'hFEDCB, 20'h12345};
      k = 0;
      while (!c_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      c_valid = 1'b0;
      wait_frames(2, 1, 2000);
      repeat (60) @(negedge clk);
      check("t6_ch0",    c_w0[0], 20'h12345);
      check("t6_ch1",    c_w1[0], 20'hFEDCB);
      check("t6_fd_cnt", c_fd_n,  1);
      check("t6_ur_cnt", c_ur_n,  0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
